ex_mdu: RTL and testbench
=========================

# ex_mdu

Multi-cycle RV32M multiply/divide unit in the execute stage. Consumes the operand/command bundle latched by the ID/EX pipeline register, in parallel with the single-cycle ALU. Iterates over 32 cycles and holds the front of the pipeline through the stall controller. Emits one registered result pulse that the EX output mux selects over the ALU result.

## Interface
Parameters:
- `XLEN`, 32, operand/result width.
- `ITERS`, 32, iteration count for shift-add and restoring divide; must equal `XLEN`.

Ports:
- `clk_in`  in  1  clock. Every state element is rising-edge.
- `rst_in`  in  1  reset, asynchronous, active-low.
- `rdy_in`  in  1  global ready. While low, the FSM, counter and datapath freeze. Outputs hold.
- `reg1_from_idex`  in  32  rs1 value (dividend / multiplicand).
- `reg2_from_idex`  in  32  rs2 value (divisor / multiplier).
- `rsd_from_idex`  in  5  destination register.
- `write_rsd_from_idex`  in  1  destination write enable.
- `cmdtype_from_idex`  in  6  command type. Value 0 is a bubble.
- `stallreq_out`  out  1  request to the stall controller to hold IF, ID and ID/EX.
- `mdu_valid_out`  out  1  one-cycle result strobe.
- `mdu_result_out`  out  32  result, valid with the strobe.
- `mdu_rsd_out`  out  5  destination register, valid with the strobe.
- `mdu_write_rsd_out`  out  1  write enable, valid with the strobe.

## Operation
- MDU command: `cmdtype` is one of MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU. Every other code is ignored.
- FSM states:
  - IDLE → BUSY: an MDU command is present and no special case applies.
  - IDLE → DONE: a special case applies.
  - BUSY → DONE: the counter reaches 0.
  - DONE → IDLE: always.
- IDLE with an MDU command:
  - Latch the operand magnitudes, signs, op, `rsd` and write enable.
  - Load the counter with `ITERS`.
- Sign handling:
  - MULH: both operands signed.
  - MULHSU: rs1 signed, rs2 unsigned.
  - MULHU, DIVU, REMU: unsigned.
  - DIV, REM: signed.
  - Signed ops iterate on magnitudes and negate the result at the end.
- Multiply: shift-add on a 64-bit accumulator.
  - MUL returns the low 32 bits.
  - MULH/MULHSU/MULHU return the high 32 bits.
- Divide: restoring, one quotient bit per cycle.
  - Quotient sign = sign(rs1) XOR sign(rs2).
  - Remainder sign = sign(rs1).
- Special cases (single-cycle path, no iteration):
  - Divisor 0:
    - DIV/DIVU → 0xFFFFFFFF.
    - REM/REMU → rs1.
  - Signed overflow, rs1 = 0x80000000 and rs2 = 0xFFFFFFFF:
    - DIV → 0x80000000.
    - REM → 0.
- DONE:
  - `mdu_valid_out` = 1; result and destination registered.
  - Inputs are ignored this cycle, because the held instruction is still on the ID/EX outputs and must not restart.
- Writes to x0 pass through unchanged. The register file discards them.
- Async reset at any point, including mid-iteration, forces the reset values below. The in-flight op is lost.

## Timing
- Reset values:
  - FSM = IDLE, counter = 0.
  - `stallreq_out` = 0, `mdu_valid_out` = 0.
  - `mdu_result_out` = 0, `mdu_rsd_out` = 0, `mdu_write_rsd_out` = 0.
- `stallreq_out` is combinational: (IDLE AND MDU command present) OR BUSY. It is low in DONE, so the held instruction leaves ID/EX on the DONE→IDLE edge.
- Normal latency:
  - Command first visible at cycle 0.
  - BUSY for cycles 1..32.
  - DONE / strobe at cycle 33.
  - Stall asserted for cycles 0..32.
- Special-case latency: strobe at cycle 1, stall asserted at cycle 0 only.
- Back-to-back MDU ops: the second is visible in IDLE at cycle 34 and its strobe appears at cycle 67.
- `rdy_in` low: hold the FSM, counter and `stallreq_out`; strobe timing stretches by the number of low cycles.
- A bubble (`cmdtype` 0) or a non-MDU command in IDLE causes no stall and no strobe.

## Structure
- `define.v` holds:
  - The eight MDU command codes, 6'h25 through 6'h2C in the order MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
  - The FSM state encodings `MDU_IDLE`, `MDU_BUSY` and `MDU_DONE`.
- One sub-module `mdu_iter`:
  - Shared 64-bit shift/add/subtract step.
  - Inputs: op class and accumulator.
  - Outputs: next accumulator.
- `ex_mdu` owns the FSM, counter, sign fix-up and special-case detection.

## Test plan
- MUL, rs1 = 7, rs2 = 0xFFFFFFFD → strobe at cycle 33, result 0xFFFFFFEB; `stallreq_out` high for exactly cycles 0..32.
- MULHU, 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE. MULH with the same operands → 0x00000000. MULHSU, 0xFFFFFFFF × 2 → 0xFFFFFFFF.
- Signed divide, rs1 = -20, rs2 = 3:
  - DIV → 0xFFFFFFFA (−6).
  - REM → 0xFFFFFFFE (−2).
- Unsigned divide, rs1 = 20, rs2 = 3:
  - DIVU → 6.
  - REMU → 2.
- Special cases, each strobing at cycle 1:
  - DIVU, rs1 = 5, rs2 = 0 → 0xFFFFFFFF.
  - REM, rs1 = 5, rs2 = 0 → 5.
  - DIV, 0x80000000 / 0xFFFFFFFF → 0x80000000.
- Pipeline behaviour:
  - Two MDU ops back-to-back → strobes at cycles 33 and 67; the held instruction is never re-issued.
  - `rdy_in` pulled low for 5 cycles mid-BUSY → strobe moves to cycle 38.
  - `rst_in` low at cycle 10 → all outputs 0 immediately; no strobe follows.

Source files
------------

// File: rtl/ex_mdu_pkg.sv
// rtl/ex_mdu_pkg.sv - RV32M command codes, FSM states and decode helpers for ex_mdu
package ex_mdu_pkg;

  localparam logic [5:0] CMD_MUL    = 6'h25;
  localparam logic [5:0] CMD_MULH   = 6'h26;
  localparam logic [5:0] CMD_MULHSU = 6'h27;
  localparam logic [5:0] CMD_MULHU  = 6'h28;
  localparam logic [5:0] CMD_DIV    = 6'h29;
  localparam logic [5:0] CMD_DIVU   = 6'h2A;
  localparam logic [5:0] CMD_REM    = 6'h2B;
  localparam logic [5:0] CMD_REMU   = 6'h2C;

  typedef enum logic [1:0] {
    MDU_IDLE = 2'd0,
    MDU_BUSY = 2'd1,
    MDU_DONE = 2'd2
  } mdu_state_e;

  typedef enum logic {
    ITER_MUL = 1'b0,
    ITER_DIV = 1'b1
  } iter_op_e;

  function automatic logic is_mdu_cmd(input logic [5:0] cmd);
    return (cmd >= CMD_MUL) && (cmd <= CMD_REMU);
  endfunction

  function automatic logic is_div_cmd(input logic [5:0] cmd);
    return (cmd >= CMD_DIV) && (cmd <= CMD_REMU);
  endfunction

endpackage

// File: rtl/mdu_iter.sv
// rtl/mdu_iter.sv - one shift-add multiply or restoring-divide step on a 2*XLEN accumulator
module mdu_iter
  import ex_mdu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  iter_op_e              op,
  input  logic [2*XLEN-1:0]     acc,
  input  logic [XLEN-1:0]       operand,
  output logic [2*XLEN-1:0]     acc_next
);

  logic [XLEN:0]   sum;
  logic [XLEN+1:0] diff;
  logic            diff_unused;

  // Multiply: {hi,lo} with multiplier in lo, shifted right each step.
  // Divide: {rem,quo}; the partial remainder needs XLEN+1 bits before the trial subtract.
  always_comb begin
    sum      = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, operand} : '0);
    diff     = {1'b0, acc[2*XLEN-1:XLEN-1]} - {2'b00, operand};
    acc_next = acc;
    if (op == ITER_MUL) begin
      acc_next = {sum, acc[XLEN-1:1]};
    end else if (diff[XLEN+1]) begin
      acc_next = {acc[2*XLEN-2:0], 1'b0};
    end else begin
      acc_next = {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
    end
  end

  assign diff_unused = diff[XLEN];

endmodule

// File: rtl/ex_mdu.sv
// rtl/ex_mdu.sv - multi-cycle RV32M multiply/divide unit with pipeline stall and result strobe
module ex_mdu
  import ex_mdu_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int ITERS = 32
) (
  input  logic            clk_in,
  input  logic            rst_in,
  input  logic            rdy_in,
  input  logic [XLEN-1:0] reg1_from_idex,
  input  logic [XLEN-1:0] reg2_from_idex,
  input  logic [4:0]      rsd_from_idex,
  input  logic            write_rsd_from_idex,
  input  logic [5:0]      cmdtype_from_idex,
  output logic            stallreq_out,
  output logic            mdu_valid_out,
  output logic [XLEN-1:0] mdu_result_out,
  output logic [4:0]      mdu_rsd_out,
  output logic            mdu_write_rsd_out
);

  localparam int              CW      = $clog2(ITERS + 1);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  mdu_state_e        state, state_next;
  logic [CW-1:0]     cnt;
  logic [2*XLEN-1:0] acc, acc_next;
  logic [XLEN-1:0]   opd;
  logic [5:0]        op;
  logic              neg_res;
  logic [4:0]        rsd_q;
  logic              wr_q;
  logic              stall;

  logic              is_cmd, is_div, is_rem, a_signed, b_signed, a_neg, b_neg;
  logic              div_zero, div_ovf, special;
  logic [XLEN-1:0]   a_mag, b_mag, special_result;

  always_comb begin
    is_cmd   = is_mdu_cmd(cmdtype_from_idex);
    is_div   = is_div_cmd(cmdtype_from_idex);
    is_rem   = (cmdtype_from_idex == CMD_REM) || (cmdtype_from_idex == CMD_REMU);
    a_signed = cmdtype_from_idex inside {CMD_MULH, CMD_MULHSU, CMD_DIV, CMD_REM};
    b_signed = cmdtype_from_idex inside {CMD_MULH, CMD_DIV, CMD_REM};
    a_neg    = a_signed && reg1_from_idex[XLEN-1];
    b_neg    = b_signed && reg2_from_idex[XLEN-1];
    a_mag    = a_neg ? -reg1_from_idex : reg1_from_idex;
    b_mag    = b_neg ? -reg2_from_idex : reg2_from_idex;
    div_zero = is_div && (reg2_from_idex == '0);
    div_ovf  = ((cmdtype_from_idex == CMD_DIV) || (cmdtype_from_idex == CMD_REM))
               && (reg1_from_idex == MIN_NEG) && (reg2_from_idex == '1);
    special  = div_zero || div_ovf;
    if (div_zero) begin
      special_result = is_rem ? reg1_from_idex : '1;
    end else begin
      special_result = is_rem ? '0 : MIN_NEG;
    end
  end

  iter_op_e iter_op;
  assign iter_op = is_div_cmd(op) ? ITER_DIV : ITER_MUL;

  mdu_iter #(.XLEN(XLEN)) u_iter (
    .op       (iter_op),
    .acc      (acc),
    .operand  (opd),
    .acc_next (acc_next)
  );

  // Sign fix-up applied to the value produced by the final iteration.
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo, rem, final_result;

  always_comb begin
    prod = neg_res ? -acc_next : acc_next;
    quo  = acc_next[XLEN-1:0];
    rem  = acc_next[2*XLEN-1:XLEN];
    case (op)
      CMD_MUL:                         final_result = prod[XLEN-1:0];
      CMD_MULH, CMD_MULHSU, CMD_MULHU: final_result = prod[2*XLEN-1:XLEN];
      CMD_REM, CMD_REMU:               final_result = neg_res ? -rem : rem;
      default:                         final_result = neg_res ? -quo : quo;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state <= MDU_IDLE;
    end else if (rdy_in) begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    stall      = 1'b0;
    case (state)
      MDU_IDLE: begin
        if (is_cmd) begin
          stall      = 1'b1;
          state_next = special ? MDU_DONE : MDU_BUSY;
        end
      end
      MDU_BUSY: begin
        stall = 1'b1;
        if (cnt == CW'(1)) state_next = MDU_DONE;
      end
      MDU_DONE: state_next = MDU_IDLE;
      default:  state_next = MDU_IDLE;
    endcase
  end

  // Gated so the stall request is also low while reset is held.
  assign stallreq_out = stall && rst_in;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      cnt               <= '0;
      acc               <= '0;
      opd               <= '0;
      op                <= '0;
      neg_res           <= 1'b0;
      rsd_q             <= '0;
      wr_q              <= 1'b0;
      mdu_valid_out     <= 1'b0;
      mdu_result_out    <= '0;
      mdu_rsd_out       <= '0;
      mdu_write_rsd_out <= 1'b0;
    end else if (rdy_in) begin
      mdu_valid_out <= 1'b0;
      case (state)
        MDU_IDLE: begin
          if (is_cmd) begin
            op      <= cmdtype_from_idex;
            rsd_q   <= rsd_from_idex;
            wr_q    <= write_rsd_from_idex;
            neg_res <= is_rem ? a_neg : (a_neg ^ b_neg);
            if (is_div) begin
              acc <= {{XLEN{1'b0}}, a_mag};
              opd <= b_mag;
            end else begin
              acc <= {{XLEN{1'b0}}, b_mag};
              opd <= a_mag;
            end
            if (special) begin
              mdu_valid_out     <= 1'b1;
              mdu_result_out    <= special_result;
              mdu_rsd_out       <= rsd_from_idex;
              mdu_write_rsd_out <= write_rsd_from_idex;
            end else begin
              cnt <= CW'(ITERS);
            end
          end
        end
        MDU_BUSY: begin
          acc <= acc_next;
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            mdu_valid_out     <= 1'b1;
            mdu_result_out    <= final_result;
            mdu_rsd_out       <= rsd_q;
            mdu_write_rsd_out <= wr_q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_mdu.sv
// tb/tb_ex_mdu.sv - directed table-driven bench for ex_mdu with an ID/EX hold model
module tb_ex_mdu;

  localparam logic [5:0] MUL = 6'h25, MULH = 6'h26, MULHSU = 6'h27, MULHU = 6'h28;
  localparam logic [5:0] DIV = 6'h29, DIVU = 6'h2A, REM = 6'h2B, REMU = 6'h2C;

  typedef struct {
    string       name;
    logic [5:0]  cmd;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
    logic [4:0]  rsd;
    logic        wr;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst, rdy, wr_i, stall, valid, o_wr;
  logic [31:0] r1, r2, result;
  logic [4:0]  rsd_i, o_rsd;
  logic [5:0]  cmd;

  always #5 clk = ~clk;

  ex_mdu #(.XLEN(32), .ITERS(32)) dut (
    .clk_in              (clk),
    .rst_in              (rst),
    .rdy_in              (rdy),
    .reg1_from_idex      (r1),
    .reg2_from_idex      (r2),
    .rsd_from_idex       (rsd_i),
    .write_rsd_from_idex (wr_i),
    .cmdtype_from_idex   (cmd),
    .stallreq_out        (stall),
    .mdu_valid_out       (valid),
    .mdu_result_out      (result),
    .mdu_rsd_out         (o_rsd),
    .mdu_write_rsd_out   (o_wr)
  );

  int          n_cmp = 0, n_bad = 0;
  int          cyc = 0;
  int          rdy_lo_from = -1, rdy_lo_to = -1;
  vec_t        pend[$];
  vec_t        tbl[$];
  int          s_cyc[$];
  logic [31:0] s_res[$];
  logic [5:0]  s_rw[$];
  bit          stall_tr[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input string n, input logic [5:0] c, input logic [31:0] a,
                              input logic [31:0] b, input logic [31:0] e, input int lat);
    vec_t v;
    v.name = n; v.cmd = c; v.a = a; v.b = b; v.exp = e; v.lat = lat;
    v.rsd = 5'd1; v.wr = 1'b1;
    return v;
  endfunction

  task automatic issue(input vec_t v);
    cmd = v.cmd; r1 = v.a; r2 = v.b; rsd_i = v.rsd; wr_i = v.wr;
  endtask

  task automatic bubble();
    cmd = 6'h00; r1 = '0; r2 = '0; rsd_i = '0; wr_i = 1'b0;
  endtask

  task automatic clear();
    cyc = 0;
    s_cyc.delete(); s_res.delete(); s_rw.delete(); stall_tr.delete();
  endtask

  // Called at edge+1; samples at edge+2 and models ID/EX advancing only when not stalled.
  task automatic run(input int n);
    bit adv;
    for (int k = 0; k < n; k++) begin
      rdy = !(cyc >= rdy_lo_from && cyc <= rdy_lo_to);
      #1;
      stall_tr.push_back(stall);
      if (valid) begin
        s_cyc.push_back(cyc);
        s_res.push_back(result);
        s_rw.push_back({o_wr, o_rsd});
      end
      adv = !stall && rdy;
      @(posedge clk);
      #1;
      if (adv) begin
        if (pend.size() > 0) issue(pend.pop_front());
        else bubble();
      end
      cyc++;
    end
  endtask

  function automatic int stall_errs_single(input int lat);
    int e = 0;
    for (int c = 0; c < stall_tr.size(); c++)
      if (stall_tr[c] != (c < lat)) e++;
    return e;
  endfunction

  initial begin
    vec_t v, v2;
    int   e;
    rst = 1'b0; rdy = 1'b1; bubble();
    repeat (2) @(posedge clk);
    #1;
    check("reset_ctl", {26'd0, stall, valid, o_wr, o_rsd[2:0]}, 32'd0);
    check("reset_rsd", {27'd0, o_rsd}, 32'd0);
    check("reset_result", result, 32'd0);
    rst = 1'b1;

    tbl.push_back(mk("mul_neg",     MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33));
    tbl.push_back(mk("mulhu_max",   MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33));
    tbl.push_back(mk("mulh_m1m1",   MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 33));
    tbl.push_back(mk("mulhsu_m1x2", MULHSU, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 33));
    tbl.push_back(mk("div_m20_3",   DIV,    32'hFFFFFFEC, 32'd3,        32'hFFFFFFFA, 33));
    tbl.push_back(mk("rem_m20_3",   REM,    32'hFFFFFFEC, 32'd3,        32'hFFFFFFFE, 33));
    tbl.push_back(mk("divu_20_3",   DIVU,   32'd20,       32'd3,        32'd6,        33));
    tbl.push_back(mk("remu_20_3",   REMU,   32'd20,       32'd3,        32'd2,        33));
    tbl.push_back(mk("divu_by0",    DIVU,   32'd5,        32'd0,        32'hFFFFFFFF, 1));
    tbl.push_back(mk("rem_by0",     REM,    32'd5,        32'd0,        32'd5,        1));
    tbl.push_back(mk("div_ovf",     DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1));
    tbl.push_back(mk("rem_ovf",     REM,    32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1));
    tbl.push_back(mk("mulh_minmin", MULH,   32'h80000000, 32'h80000000, 32'h40000000, 33));
    tbl.push_back(mk("div_7_m2",    DIV,    32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 33));
    tbl.push_back(mk("rem_7_m2",    REM,    32'd7,        32'hFFFFFFFE, 32'd1,        33));
    tbl.push_back(mk("divu_wide",   DIVU,   32'hFFFFFFFF, 32'h80000001, 32'd1,        33));
    tbl.push_back(mk("remu_wide",   REMU,   32'hFFFFFFFF, 32'h80000001, 32'h7FFFFFFE, 33));
    tbl.push_back(mk("mul_m1m1",    MUL,    32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1,        33));
    tbl.push_back(mk("remu_by0",    REMU,   32'd5,        32'd0,        32'd5,        1));
    tbl.push_back(mk("div_by0",     DIV,    32'hFFFFFFFF, 32'd0,        32'hFFFFFFFF, 1));

    foreach (tbl[i]) begin
      v = tbl[i];
      v.rsd = 5'(i * 3);
      v.wr  = (i % 2) == 1;
      clear();
      issue(v);
      run(v.lat + 3);
      check({v.name, "_nstrobe"}, 32'(s_cyc.size()), 32'd1);
      check({v.name, "_cycle"}, (s_cyc.size() > 0) ? 32'(s_cyc[0]) : 32'hFFFFFFFF, 32'(v.lat));
      check({v.name, "_result"}, (s_res.size() > 0) ? s_res[0] : 32'hDEADBEEF, v.exp);
      check({v.name, "_rsd_wr"}, (s_rw.size() > 0) ? {26'd0, s_rw[0]} : 32'hDEADBEEF,
            {26'd0, v.wr, v.rsd});
      check({v.name, "_stall"}, 32'(stall_errs_single(v.lat)), 32'd0);
    end

    // Back-to-back: second op enters IDLE at cycle 34.
    clear();
    v  = mk("b2b_mul", MUL, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 33);
    v2 = mk("b2b_divu", DIVU, 32'd20, 32'd3, 32'd6, 33);
    v2.rsd = 5'd9;
    pend.push_back(v2);
    issue(v);
    run(72);
    check("b2b_nstrobe", 32'(s_cyc.size()), 32'd2);
    check("b2b_cycle0", (s_cyc.size() > 0) ? 32'(s_cyc[0]) : 32'hFFFFFFFF, 32'd33);
    check("b2b_cycle1", (s_cyc.size() > 1) ? 32'(s_cyc[1]) : 32'hFFFFFFFF, 32'd67);
    check("b2b_result0", (s_res.size() > 0) ? s_res[0] : 32'hDEADBEEF, 32'hFFFFFFEB);
    check("b2b_result1", (s_res.size() > 1) ? s_res[1] : 32'hDEADBEEF, 32'd6);
    check("b2b_rsd1", (s_rw.size() > 1) ? {26'd0, s_rw[1]} : 32'hDEADBEEF, 32'h29);
    e = 0;
    for (int c = 0; c < stall_tr.size(); c++)
      if (stall_tr[c] != (c <= 32 || (c >= 34 && c <= 66))) e++;
    check("b2b_stall", 32'(e), 32'd0);

    // rdy low for cycles 10..14 stretches the strobe by 5.
    clear();
    rdy_lo_from = 10; rdy_lo_to = 14;
    v = mk("rdy_mul", MUL, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 38);
    issue(v);
    run(41);
    rdy_lo_from = -1; rdy_lo_to = -1;
    check("rdy_nstrobe", 32'(s_cyc.size()), 32'd1);
    check("rdy_cycle", (s_cyc.size() > 0) ? 32'(s_cyc[0]) : 32'hFFFFFFFF, 32'd38);
    check("rdy_result", (s_res.size() > 0) ? s_res[0] : 32'hDEADBEEF, 32'hFFFFFFEB);
    check("rdy_stall", 32'(stall_errs_single(38)), 32'd0);

    // Bubble and non-MDU codes never stall or strobe.
    for (int j = 0; j < 4; j++) begin
      logic [5:0] codes [4];
      codes[0] = 6'h00; codes[1] = 6'h24; codes[2] = 6'h2D; codes[3] = 6'h3F;
      clear();
      v = mk("nonmdu", codes[j], 32'd20, 32'd0, 32'd0, 0);
      issue(v);
      run(5);
      e = 0;
      foreach (stall_tr[c]) if (stall_tr[c]) e++;
      check($sformatf("nonmdu_%0h", codes[j]), 32'(e + s_cyc.size()), 32'd0);
    end

    // Async reset mid-iteration at cycle 10.
    clear();
    v = mk("rst_mul", MUL, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 33);
    v.rsd = 5'd17;
    issue(v);
    run(10);
    rst = 1'b0;
    bubble();
    #1;
    check("midrst_ctl", {27'd0, stall, valid, o_wr, 2'b00}, 32'd0);
    check("midrst_rsd", {27'd0, o_rsd}, 32'd0);
    check("midrst_result", result, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    clear();
    run(40);
    e = 0;
    foreach (stall_tr[c]) if (stall_tr[c]) e++;
    check("midrst_nostrobe", 32'(s_cyc.size()), 32'd0);
    check("midrst_nostall", 32'(e), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
